hilo_div_unit: RTL

//  Multi-cycle divide unit plus HI/LO architectural registers for the EX stage.

---
 rtl/hilo_div_unit_pkg.sv | 12 +
 rtl/hilo_div_unit_div_iter_core.sv | 75 +++++++
 rtl/hilo_div_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO divide unit: FSM state encodings and width default.
package hilo_div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_FIX  = 2'b10
    } div_state_e;

endpackage

// File: rtl/hilo_div_unit_div_iter_core.sv
// Restoring shift-subtract divider datapath: holds remainder, quotient, divisor
// and the step counter; performs one restoring step per asserted step cycle.
module div_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem,
    output logic [WIDTH-1:0] quo,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   r_sh_s;
    logic [WIDTH:0]   diff_s;

    // Next-state for the datapath: load operands, run one restoring step, or hold.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        // {R,Q} shifted left by one; the top bit is needed because 2R+1 can exceed WIDTH bits.
        r_sh_s = {rem_q, quo_q[WIDTH-1]};
        diff_s = r_sh_s - {1'b0, dvs_q};
        if (load) begin
            rem_d = {WIDTH{1'b0}};
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = CW'(WIDTH - 1);
        end else if (step) begin
            if (!diff_s[WIDTH]) begin
                rem_d = diff_s[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = r_sh_s[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            // Wraps after the final step; the FSM has left CALC by then.
            cnt_d = cnt_q - CW'(1'b1);
        end else begin
            rem_d = rem_q;
            quo_d = quo_q;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= {WIDTH{1'b0}};
            quo_q <= {WIDTH{1'b0}};
            dvs_q <= {WIDTH{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign rem  = rem_q;
    assign quo  = quo_q;
    assign last = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/hilo_div_unit.sv
// EX-stage divide unit with HI/LO architectural registers: DIV/DIVU sequencing,
// sign handling, MTHI/MTLO moves and pipeline flush.
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Two's complement negation when neg is set. Used both for operand
    // magnitudes (the WIDTH+1-bit magnitude of -2^(WIDTH-1) has a zero top bit,
    // so the WIDTH-bit result is exact) and for result fix-up (wraps mod 2^WIDTH).
    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        if (neg) begin
            cond_neg = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cond_neg = v;
        end
    endfunction

    div_state_e       state_q, state_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_div_q, zero_div_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             core_load_s;
    logic             core_step_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] core_rem_s;
    logic [WIDTH-1:0] core_quo_s;
    logic             core_last_s;

    assign a_mag_s = cond_neg(is_signed & op_a[WIDTH-1], op_a);
    assign b_mag_s = cond_neg(is_signed & op_b[WIDTH-1], op_b);

    div_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load_s),
        .step     (core_step_s),
        .dividend (a_mag_s),
        .divisor  (b_mag_s),
        .rem      (core_rem_s),
        .quo      (core_quo_s),
        .last     (core_last_s)
    );

    // FSM next-state, sign flags, HI/LO updates and done pulse; flush overrides all.
    always_comb begin
        state_d     = state_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        zero_div_d  = zero_div_q;
        done_d      = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        core_load_s = 1'b0;
        core_step_s = 1'b0;
        if (flush) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        core_load_s = 1'b1;
                        neg_quo_d   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        neg_rem_d   = is_signed & op_a[WIDTH-1];
                        zero_div_d  = (op_b == {WIDTH{1'b0}});
                        state_d     = DIV_CALC;
                    end else begin
                        if (mthi) begin
                            hi_d = wdata;
                        end else begin
                            hi_d = hi_q;
                        end
                        if (mtlo) begin
                            lo_d = wdata;
                        end else begin
                            lo_d = lo_q;
                        end
                    end
                end
                DIV_CALC: begin
                    core_step_s = 1'b1;
                    if (core_last_s) begin
                        state_d = DIV_FIX;
                    end else begin
                        state_d = DIV_CALC;
                    end
                end
                DIV_FIX: begin
                    // Divide by zero: quotient forced to all ones; the core's
                    // remainder equals |a|, so the sign fix-up restores raw op_a.
                    if (zero_div_q) begin
                        lo_d = {WIDTH{1'b1}};
                    end else begin
                        lo_d = cond_neg(neg_quo_q, core_quo_s);
                    end
                    hi_d    = cond_neg(neg_rem_q, core_rem_s);
                    done_d  = 1'b1;
                    state_d = DIV_IDLE;
                end
                default: begin
                    state_d = DIV_IDLE;
                end
            endcase
        end
    end

    // Control and architectural registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_div_q <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            zero_div_q <= zero_div_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy = (state_q != DIV_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
